spi_reg_bank_poci: RTL and testbench
====================================

// Module: spi_reg_bank_poci
// PURPOSE
//  Downstream consumer of the PICO decode stage. Holds the chip's digital configuration registers.
//  - Write path: captures each decoded data byte into the register at the supplied address.
//  - Read path: serialises the register selected by the address pointer onto POCI, MSB first.
//  - Visibility: register contents are exported in parallel to the analog/config fabric.
// PARAMETERS
//  NUM_REGS  16       number of 8-bit registers; legal addresses 0..NUM_REGS-1 (2..256)
//  RO_MASK   16'h0000 bit i set -> register i is read-only from SPI (writes dropped, flagged)
// PORTS
//  sclk       in   1            spi clock; the only clock; all state updates on posedge
//  rstn       in   1            synchronous active-low reset, sampled on posedge sclk
//  wr_valid   in   1            one-cycle strobe: wr_data is a complete byte for wr_addr
//  wr_addr    in   8            target register address for the write
//  wr_data    in   8            write byte
//  rd_addr    in   8            register address to serialise (PICO mux control / address pointer)
//  byte_start in   1            one-cycle strobe aligning POCI to a new byte frame
//  poci       out  1            serial read data, MSB first
//  reg_out    out  NUM_REGS*8   flattened register contents; reg i at [8*i+7:8*i]
//  bit_cnt    out  3            POCI bit index within current byte (0 = MSB being driven)
//  wr_err     out  1            sticky: write to out-of-range or read-only address seen
// BEHAVIOUR
//  Reset (rstn=0 at posedge sclk): all registers, shift_reg, bit_cnt and wr_err go to 0; poci=0.
//   - Reset dominates every other input in the same cycle.
//  Write path:
//   - wr_valid=1 and wr_addr<NUM_REGS and !RO_MASK[wr_addr] -> reg[wr_addr] <= wr_data.
//   - Write latency is 1 cycle: visible on reg_out after that posedge.
//   - wr_valid=1 with wr_addr>=NUM_REGS or RO target -> no register changes; wr_err <= 1.
//   - wr_err stays set until reset.
//   - wr_valid=0 -> wr_addr/wr_data are ignored; wr_data=0 is a legal value to write.
//  Read path (8-bit shift_reg, 3-bit bit_cnt; poci = shift_reg[7], combinational from flop):
//   - LOAD occurs when byte_start=1 OR bit_cnt==7. A LOAD sets:
//     shift_reg <= rdval(rd_addr) and bit_cnt <= 0.
//   - Otherwise: shift_reg <= {shift_reg[6:0],1'b0} and bit_cnt <= bit_cnt+1.
//   - Effect: back-to-back bytes stream with no gap, one byte per 8 sclk.
//   - rdval(a) = reg[a] if a<NUM_REGS, else 8'h00. Read-only regs read normally.
//   - Write-through bypass: LOAD and a valid write to the same address in the same cycle
//     -> shift_reg gets wr_data, not the stale register value.
//   - byte_start mid-byte abandons the current byte and reloads immediately (realign); no error.
//   - byte_start coincident with bit_cnt==7 -> a single LOAD, no double count.
//   - Address wrap: rd_addr/wr_addr are taken as given. Pointer increment and wrap are the
//     upstream stage's responsibility; out-of-range reads return 0x00.
//  Timing: first POCI bit (MSB) is valid in the cycle after the LOAD edge, through to the next edge.
//  No combinational path from inputs to poci or reg_out.
// TESTING
//  1. Reset: preload regs, pulse rstn=0 one cycle -> reg_out=0, wr_err=0, poci=0, bit_cnt=0.
//  2. Write: wr_valid, addr 3, data 8'hA5 -> reg_out[31:24]=8'hA5 next cycle; others unchanged.
//  3. Read: reg5=8'hC3, rd_addr=5, byte_start -> poci 1,1,0,0,0,0,1,1 over next 8 cycles;
//     auto-reload at bit_cnt 7.
//  4. Errors: write to addr 16 (NUM_REGS=16) and to an RO reg (RO_MASK=16'h0001, addr 0)
//     -> no reg change, wr_err=1 sticky.
//  5. Bypass/realign:
//     - Write 8'h3C to addr 2 on the LOAD cycle with rd_addr=2 -> poci streams 8'h3C.
//     - byte_start at bit_cnt=4 -> bit_cnt=0, new byte restarts.
//  6. Mid-operation reset: assert rstn=0 at bit_cnt=3 during a read and a write
//     -> all state zero, write dropped; streaming restarts cleanly after release.

Source files
------------

// File: rtl/spi_reg_bank_poci_if.sv
// Bus between the PICO decode stage and the register bank: write strobe, read pointer,
// POCI byte framing and the parallel register export.
interface spi_reg_bank_poci_if #(
    parameter int NUM_REGS = 16
);
    // wr_valid and byte_start are one-cycle strobes with no ready/back-pressure:
    // the bank accepts wr_addr/wr_data whenever wr_valid is high on a posedge.
    logic                  wr_valid;
    logic [7:0]            wr_addr;
    logic [7:0]            wr_data;
    logic [7:0]            rd_addr;
    logic                  byte_start;
    logic                  poci;
    logic [NUM_REGS*8-1:0] reg_out;
    logic [2:0]            bit_cnt;
    logic                  wr_err;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_addr, byte_start,
        input  poci, reg_out, bit_cnt, wr_err
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_addr, byte_start,
        output poci, reg_out, bit_cnt, wr_err
    );
endinterface

// File: rtl/spi_reg_bank_poci.sv
// Configuration register bank: byte writes from the PICO decoder, MSB-first POCI
// serialisation of the addressed register, and a parallel export of all registers.
module spi_reg_bank_poci #(
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input logic                  sclk,
    input logic                  rstn,
    spi_reg_bank_poci_if.slave   bus
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [7:0]    regs [NUM_REGS];
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
    logic          wr_err;

    logic          wr_in_range;
    logic          rd_in_range;
    logic          wr_ok;
    logic          load;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [7:0]    rd_val;

    assign wa          = bus.wr_addr[AW-1:0];
    assign ra          = bus.rd_addr[AW-1:0];
    assign wr_in_range = ({24'd0, bus.wr_addr} < 32'(NUM_REGS));
    assign rd_in_range = ({24'd0, bus.rd_addr} < 32'(NUM_REGS));
    assign wr_ok       = bus.wr_valid && wr_in_range && !RO_MASK[wa];
    assign load        = bus.byte_start || (bit_cnt == 3'd7);

    // A write landing on the register being loaded this cycle is forwarded,
    // so the streamed byte never shows the stale value.
    always_comb begin
        rd_val = 8'h00;
        if (rd_in_range) rd_val = regs[ra];
        if (wr_ok && (bus.wr_addr == bus.rd_addr)) rd_val = bus.wr_data;
    end

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            wr_err <= 1'b0;
        end else if (bus.wr_valid) begin
            if (wr_ok) regs[wa] <= bus.wr_data;
            else       wr_err   <= 1'b1;
        end
    end

    // byte_start and the bit-7 wrap both funnel into the same single load.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
        end else if (load) begin
            shift_reg <= rd_val;
            bit_cnt   <= 3'd0;
        end else begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            bit_cnt   <= bit_cnt + 3'd1;
        end
    end

    always_comb begin
        bus.reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) bus.reg_out[8*i +: 8] = regs[i];
    end

    assign bus.poci    = shift_reg[7];
    assign bus.bit_cnt = bit_cnt;
    assign bus.wr_err  = wr_err;
endmodule

// File: tb/tb_spi_reg_bank_poci.sv
// Directed and randomized bench for spi_reg_bank_poci against a byte/index level model.
module tb_spi_reg_bank_poci;
    localparam int          NREG = 16;
    localparam logic [15:0] RO   = 16'h0001;

    logic sclk = 1'b0;
    logic rstn = 1'b0;
    spi_reg_bank_poci_if #(.NUM_REGS(NREG)) bus ();

    spi_reg_bank_poci #(.NUM_REGS(NREG), .RO_MASK(RO)) dut (
        .sclk (sclk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] m_regs [NREG];
    logic       m_err;
    logic [7:0] m_byte;
    int         m_pos;

    function automatic logic [127:0] model_reg_out();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from the inputs sampled on the edge, then check after it.
    task automatic step();
        logic       wok;
        logic [7:0] rv;
        @(posedge sclk);
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
            m_err  = 1'b0;
            m_byte = 8'h00;
            m_pos  = 0;
        end else begin
            wok = bus.wr_valid && (int'(bus.wr_addr) < NREG) && !RO[bus.wr_addr[3:0]];
            rv  = (int'(bus.rd_addr) < NREG) ? m_regs[bus.rd_addr[3:0]] : 8'h00;
            if (wok && bus.wr_addr == bus.rd_addr) rv = bus.wr_data;
            if (bus.wr_valid && !wok) m_err = 1'b1;
            if (wok) m_regs[bus.wr_addr[3:0]] = bus.wr_data;
            if (bus.byte_start || m_pos == 7) begin
                m_byte = rv;
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
        #1;
        check("poci",    bus.poci,    m_byte[7 - m_pos]);
        check("bit_cnt", bus.bit_cnt, m_pos);
        check("wr_err",  bus.wr_err,  m_err);
        check("reg_out", bus.reg_out, model_reg_out());
    endtask

    task automatic idle();
        bus.wr_valid   = 1'b0;
        bus.byte_start = 1'b0;
    endtask

    task automatic write(input logic [7:0] a, input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        step();
        bus.wr_valid = 1'b0;
    endtask

    logic [7:0] got;
    logic [7:0] pat;

    initial begin
        bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_addr = 0;  bus.byte_start = 0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_err = 0; m_byte = 0; m_pos = 0;

        // Reset after preloading
        rstn = 0; step(); step();
        rstn = 1;
        write(8'd1, 8'h11); write(8'd9, 8'h99);
        rstn = 0; step();
        check("rst_reg_out", bus.reg_out, 128'h0);
        check("rst_wr_err",  bus.wr_err,  1'b0);
        check("rst_poci",    bus.poci,    1'b0);
        check("rst_bit_cnt", bus.bit_cnt, 3'd0);
        rstn = 1;

        // Write
        write(8'd3, 8'hA5);
        check("wr_a5", bus.reg_out[31:24], 8'hA5);
        check("wr_others", {bus.reg_out[127:32], bus.reg_out[23:0]}, 120'h0);
        write(8'd6, 8'h00);

        // Read C3 with auto reload
        write(8'd5, 8'hC3);
        pat = 8'hC3;
        bus.rd_addr = 8'd5; bus.byte_start = 1; step(); bus.byte_start = 0;
        for (int i = 0; i < 8; i++) begin
            check("rd_c3_bit", bus.poci, pat[7 - i]);
            if (i < 7) step();
        end
        check("rd_cnt7", bus.bit_cnt, 3'd7);
        step();
        check("rd_reload_cnt",  bus.bit_cnt, 3'd0);
        check("rd_reload_poci", bus.poci,    1'b1);

        // Errors: out of range and read-only
        write(8'd16, 8'hFF);
        check("err_oor", bus.wr_err, 1'b1);
        write(8'd0, 8'h77);
        check("err_ro_reg0", bus.reg_out[7:0], 8'h00);
        write(8'd4, 8'h44);
        check("err_sticky", bus.wr_err, 1'b1);

        // Bypass on the load cycle
        bus.rd_addr = 8'd2; bus.wr_valid = 1; bus.wr_addr = 8'd2; bus.wr_data = 8'h3C;
        bus.byte_start = 1; step(); idle();
        got = '0;
        for (int i = 0; i < 8; i++) begin
            got = {got[6:0], bus.poci};
            if (i < 7) step();
        end
        check("bypass_3c", got, 8'h3C);

        // Realign mid-byte
        bus.rd_addr = 8'd5; bus.byte_start = 1; step(); idle();
        for (int i = 0; i < 4; i++) step();
        check("realign_pre", bus.bit_cnt, 3'd4);
        bus.rd_addr = 8'd3; bus.byte_start = 1; step(); idle();
        check("realign_cnt",  bus.bit_cnt, 3'd0);
        check("realign_poci", bus.poci,    1'b1);

        // Out-of-range read returns zero
        bus.rd_addr = 8'd200; bus.byte_start = 1; step(); idle();
        got = '0;
        for (int i = 0; i < 8; i++) begin
            got = {got[6:0], bus.poci};
            if (i < 7) step();
        end
        check("rd_oor", got, 8'h00);

        // Mid-operation reset with a concurrent write
        bus.rd_addr = 8'd5; bus.byte_start = 1; step(); idle();
        for (int i = 0; i < 3; i++) step();
        check("mid_pre_cnt", bus.bit_cnt, 3'd3);
        rstn = 0; bus.wr_valid = 1; bus.wr_addr = 8'd7; bus.wr_data = 8'h55; step();
        idle(); rstn = 1;
        check("mid_rst_regs", bus.reg_out, 128'h0);
        check("mid_rst_err",  bus.wr_err,  1'b0);
        write(8'd4, 8'h96);
        bus.rd_addr = 8'd4; bus.byte_start = 1; step(); idle();
        got = '0;
        for (int i = 0; i < 8; i++) begin
            got = {got[6:0], bus.poci};
            if (i < 7) step();
        end
        check("mid_restart", got, 8'h96);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rstn           = ($urandom_range(0, 99) != 0);
            bus.wr_valid   = ($urandom_range(0, 2) == 0);
            bus.wr_addr    = 8'($urandom_range(0, 18));
            bus.wr_data    = 8'($urandom);
            bus.rd_addr    = ($urandom_range(0, 9) == 0) ? bus.wr_addr : 8'($urandom_range(0, 18));
            bus.byte_start = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
